// File: rtl/seq_detector_param_if.sv
// Serial detector bus: bit stream and runtime configuration in, match flag and counter out.
// master drives the stream and configuration; slave is the detector.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             x;
    logic             x_valid;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] len_in;
    logic             overlap_in;
    logic             cnt_clr;
    logic             z;
    logic             z_q;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, x_valid, pat_load, pat_in, len_in, overlap_in, cnt_clr,
        input  z, z_q, match_cnt
    );

    modport slave (
        input  x, x_valid, pat_load, pat_in, len_in, overlap_in, cnt_clr,
        output z, z_q, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: z is zero-latency Mealy, z_q and match_cnt one edge later.
// No backpressure: x is consumed on every x_valid cycle; pat_load takes priority over x_valid.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_detector_param_if.slave bus
);
    localparam int               LEN_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic             ovl_q,  ovl_d;
    // Only the newest PAT_W-1 bits are kept; the oldest would never reach the comparator.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             zr_q,   zr_d;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] len_clamped;
    logic             pat_hit;
    logic             fill_ok;
    logic             z;

    always_comb begin
        cand     = {hist_q, bus.x};
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        pat_hit = (((cand ^ pat_q) & len_mask) == '0);
        fill_ok = (({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q});
        z       = bus.x_valid & ~bus.pat_load & ~reset & fill_ok & pat_hit;

        len_clamped = bus.len_in;
        if (bus.len_in == '0 || bus.len_in > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        zr_d   = z;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            len_d  = len_clamped;
            ovl_d  = bus.overlap_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.x_valid) begin
            if (z && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = cand[PAT_W-2:0];
                if (fill_q != LEN_MAX) begin
                    fill_d = fill_q + LEN_W'(1);
                end
            end
        end

        // A clear that coincides with a match keeps that match.
        if (bus.cnt_clr) begin
            cnt_d = z ? CNT_W'(1) : '0;
        end else if (z && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PAT_RST;
            len_q  <= LEN_MAX;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            zr_q   <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            zr_q   <= zr_d;
        end
    end

    assign bus.z         = z;
    assign bus.z_q       = zr_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic against a
// queue-based model that keeps the valid bits seen since the last history clear.
module tb_seq_detector_param;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(
        .PAT_W  (PAT_W),
        .PAT_RST(4'b1011),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    bit         m_bits[$];
    logic [3:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    bit         m_zq;

    logic last_z;
    int   obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat = 4'b1011;
        m_len = PAT_W;
        m_ovl = 1'b1;
        m_cnt = 0;
        m_zq  = 1'b0;
    endtask

    // Match when the last len valid bits (x being the newest) spell the pattern, newest = pat[0].
    function automatic bit model_z(input bit xi, input bit v, input bit ld, input bit r);
        if (r || ld || !v) return 1'b0;
        if (m_bits.size() + 1 < m_len) return 1'b0;
        if (xi != m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++) begin
            if (m_bits[m_bits.size() - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input logic xi, input logic v, input logic ld, input logic [3:0] p,
                        input logic [LEN_W-1:0] l, input logic o, input logic clr, input logic r);
        bit ez;
        int nl;
        @(negedge clk);
        bus.x = xi; bus.x_valid = v; bus.pat_load = ld; bus.pat_in = p;
        bus.len_in = l; bus.overlap_in = o; bus.cnt_clr = clr; reset = r;
        #1;
        ez = model_z(xi, v, ld, r);
        chk("z", {31'd0, bus.z}, {31'd0, ez});
        chk("z_q", {31'd0, bus.z_q}, {31'd0, m_zq});
        chk("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
        last_z  = bus.z;
        obs_cnt = int'(bus.match_cnt);
        if (r) begin
            model_reset();
        end else begin
            if (ld) begin
                nl = int'(l);
                if (nl == 0 || nl > PAT_W) nl = PAT_W;
                m_pat = p; m_len = nl; m_ovl = o;
                m_bits.delete();
            end else if (v) begin
                if (ez && !m_ovl) m_bits.delete();
                else begin
                    m_bits.push_back(xi);
                    if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                end
            end
            if (clr) m_cnt = ez ? 1 : 0;
            else if (ez && m_cnt < CNT_MAX) m_cnt++;
            m_zq = ez;
        end
    endtask

    task automatic bit_in(input logic xi);
        step(xi, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] p, input logic [LEN_W-1:0] l, input logic o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b1, 1'b0);
    endtask

    initial begin
        logic [10:0] stream;
        logic [10:0] zmask;
        int          zcount;
        int          sat_exp[5];

        stream  = 11'b110_1110_1101; // bit i of stream is the (i+1)-th bit sent
        sat_exp = '{1, 2, 3, 3, 3};
        bus.x = 1'b0; bus.x_valid = 1'b0; bus.pat_load = 1'b0; bus.pat_in = '0;
        bus.len_in = '0; bus.overlap_in = 1'b0; bus.cnt_clr = 1'b0;
        reset = 1'b1;
        model_reset();

        step(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_z", {31'd0, last_z}, 32'd0);

        // Default pattern, overlapping: hits on bits 4, 7, 11.
        zmask = '0;
        for (int i = 0; i < 11; i++) begin
            bit_in(stream[i]);
            zmask[i] = last_z;
        end
        chk("ovl_zmask", 32'(zmask), 32'h448);
        idle();
        chk("ovl_cnt", 32'(obs_cnt), 32'd3);

        // Non-overlapping: hits on bits 4 and 11 only.
        load(4'b1011, 3'd4, 1'b0);
        zmask = '0;
        for (int i = 0; i < 11; i++) begin
            bit_in(stream[i]);
            zmask[i] = last_z;
        end
        chk("novl_zmask", 32'(zmask), 32'h408);
        idle();
        chk("novl_cnt", 32'(obs_cnt), 32'd2);

        // Two-bit pattern 01 with a valid gap inside the first sequence.
        load(4'b0001, 3'd2, 1'b1);
        zcount = 0;
        bit_in(1'b0); zcount += int'(last_z);
        idle();
        bit_in(1'b1); zcount += int'(last_z);
        chk("gap_hit", {31'd0, last_z}, 32'd1);
        bit_in(1'b0); zcount += int'(last_z);
        bit_in(1'b1); zcount += int'(last_z);
        bit_in(1'b1); zcount += int'(last_z);
        chk("gap_zcount", 32'(zcount), 32'd2);
        idle();
        chk("gap_cnt", 32'(obs_cnt), 32'd2);

        // Counter saturation and clear interaction.
        step(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bit_in(1'b0);
            bit_in(1'b1);
            idle();
            chk("sat_cnt", 32'(obs_cnt), 32'(sat_exp[k]));
        end
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("clr_hit_cnt", 32'(obs_cnt), 32'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("clr_miss_cnt", 32'(obs_cnt), 32'd0);

        // Mid-stream reset discards the partial match.
        load(4'b0000, 3'd2, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        step(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b1);
        bit_in(1'b1);
        chk("rst_discard", {31'd0, last_z}, 32'd0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("rst_pre", {31'd0, last_z}, 32'd0);
        bit_in(1'b1);
        chk("rst_after", {31'd0, last_z}, 32'd1);

        // len_in = 0 clamps to full width; load on a completing bit kills the match.
        load(4'b0110, 3'd0, 1'b1);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        chk("len0_pre", {31'd0, last_z}, 32'd0);
        bit_in(1'b0);
        chk("len0_hit", {31'd0, last_z}, 32'd1);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        step(1'b0, 1'b1, 1'b1, 4'b0110, 3'd4, 1'b1, 1'b0, 1'b0);
        chk("load_kill_z", {31'd0, last_z}, 32'd0);
        idle();
        chk("load_kill_cnt", 32'(obs_cnt), 32'd1);
        zcount = 0;
        bit_in(1'b1); zcount += int'(last_z);
        bit_in(1'b1); zcount += int'(last_z);
        bit_in(1'b0); zcount += int'(last_z);
        chk("load_fill0", 32'(zcount), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) < 3),
                 4'($urandom),
                 LEN_W'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
